// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store size encodings, MEM-stage state
// encoding and small helpers for access legality and byte lane setup.
package cpu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // 011, 110 and 111 have no load/store meaning.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                 f3 == F3_LBU || f3 == F3_LHU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (f3 == F3_LH || f3 == F3_LHU) mis = off[0];
        else if (f3 == F3_LW)           mis = (off != 2'b00);
        return mis;
    endfunction

    // funct3[1:0] carries the size for both signed and unsigned variants.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum across all lanes; byte enables pick the lane.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it. Purely combinational so a cache fill path can
// share it.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select followed by extension according to the access type.
    always_comb begin
        sel_byte = 8'h00;
        sel_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (off)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        case (funct3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  result = {24'h000000, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  result = {16'h0000, sel_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage. Converts EX/MEM load/store control into a single
// outstanding req/ack data-memory transaction, formats load data into
// read_q and stalls the pipeline while the access is in flight. The DONE
// state keeps a stalled, still-held instruction from issuing twice.
module mem_access_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        e_MemRead,
    input  logic        e_MemWrite,
    input  logic [2:0]  e_funct3,
    input  logic [31:0] e_alu_result,
    input  logic [31:0] e_store_data,
    input  logic [4:0]  e_rd,
    input  logic        e_RegWrite,
    input  logic        e_MemToReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] m_read_data,
    output logic [31:0] m_reg_data,
    output logic [4:0]  m_rd,
    output logic        m_RegWrite,
    output logic        m_MemToReg,
    output logic        mem_stall,
    output logic        mem_err
);

    mem_state_t  state_q, state_d;
    logic [29:0] addr_q,  addr_d;
    logic        we_q,    we_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q,    f3_d;
    logic [1:0]  off_q,   off_d;
    logic [31:0] read_q,  read_d;

    logic        access;
    logic        bad_access;
    logic [31:0] aligned;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .funct3 (f3_q),
        .off    (off_q),
        .result (aligned)
    );

    // Next state, request latching and load capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        off_d      = off_q;
        read_d     = read_q;
        access     = e_MemRead | e_MemWrite;
        bad_access = f3_illegal(e_funct3) | f3_misaligned(e_funct3, e_alu_result[1:0]);
        case (state_q)
            IDLE: begin
                if (access && !bad_access) begin
                    state_d = REQ;
                    addr_d  = e_alu_result[31:2];
                    we_d    = e_MemWrite;
                    be_d    = byte_en(e_funct3, e_alu_result[1:0]);
                    wdata_d = store_data(e_funct3, e_store_data);
                    f3_d    = e_funct3;
                    off_d   = e_alu_result[1:0];
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    if (!we_q) read_d = aligned;
                end
            end
            DONE: begin
                if (!stall_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode and writeback passthrough.
    always_comb begin
        mem_err     = (state_q == IDLE) && access && bad_access;
        mem_stall   = ((state_q == IDLE) && access && !bad_access) || (state_q == REQ);
        dmem_req    = (state_q == REQ);
        dmem_we     = we_q;
        dmem_addr   = {addr_q, 2'b00};
        dmem_be     = be_q;
        dmem_wdata  = wdata_q;
        m_read_data = read_q;
        m_reg_data  = e_alu_result;
        m_rd        = e_rd;
        m_MemToReg  = e_MemToReg;
        m_RegWrite  = e_RegWrite && !mem_err;
    end

    // State and request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            read_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            read_q  <= read_d;
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage between the EX/MEM register and `mem_wb_buffer`. It turns the load/store control from EX/MEM into a single-outstanding req/ack transaction on the data-memory port, with byte enables and store-data replication. Load data is aligned and sign/zero-extended, then held stable for the MEM/WB capture. While an access is in flight, the stage stalls the pipeline.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- `clk` in 1: sole clock
- `rst_n` in 1: reset, synchronous, active-low
- `stall_in` in 1: global stall from other stages; the pipeline does not advance while high
- `e_MemRead`, `e_MemWrite` in 1: load/store request from EX/MEM
- `e_funct3` in 3: access size/sign
- `e_alu_result` in 32: effective address / ALU result
- `e_store_data` in 32: rs2 value
- `e_rd` in 5: destination register
- `e_RegWrite`, `e_MemToReg` in 1: writeback control
- `dmem_req` out 1: request valid
- `dmem_we` out 1: write
- `dmem_addr` out 32: word address, bits [1:0] = 0
- `dmem_be` out 4: byte enables
- `dmem_wdata` out 32: write data
- `dmem_ack` in 1: completion
- `dmem_rdata` in 32: read word, valid with ack
- `m_read_data` out 32: formatted load data
- `m_reg_data` out 32: `e_alu_result` passthrough
- `m_rd` out 5, `m_RegWrite` out 1, `m_MemToReg` out 1: to MEM/WB
- `mem_stall` out 1: MEM stage busy
- `mem_err` out 1: misaligned access or illegal `e_funct3`

## Operation
- FSM states and transitions:
  - IDLE: if (`e_MemRead` | `e_MemWrite`) and no error → REQ.
  - REQ: hold until `dmem_ack`, then → DONE.
  - DONE: → IDLE when `stall_in` = 0; otherwise stay.
- DONE blocks re-issue of the same, still-held instruction.
- Request latching: on the IDLE→REQ transition, latch `dmem_addr` = {`e_alu_result`[31:2], 2'b00}, `dmem_we`, `dmem_be`, `dmem_wdata`, `e_funct3` and offset [1:0]. These are held stable through REQ.
- `dmem_req` = (state == REQ); it is 0 in IDLE and DONE.
- Byte enables / write data:
  - Byte access (funct3 000/100): be = 0001 << off; wdata = {4{data[7:0]}}.
  - Half access (001/101): be = 0011 << off; wdata = {2{data[15:0]}}.
  - Word access (010): be = 1111; wdata = data.
  - Loads also drive these be values; wdata on loads is don't-care.
- Load formatting on ack: select the byte/half at the latched offset.
  - Sign-extend for 000/001; zero-extend for 100/101; 010 passes the word through.
  - The result is written into the `read_q` register.
  - Stores leave `read_q` unchanged.
- `m_read_data` = `read_q` at all times.
- Errors: `mem_err` is combinational in IDLE.
  - Misaligned: half with off[0] = 1, or word with off ≠ 0.
  - Illegal: funct3 ∈ {011, 110, 111} with MemRead or MemWrite.
  - On error: no request is issued, state stays IDLE, `m_RegWrite` is forced to 0 and `mem_stall` = 0.
- `mem_stall` = (IDLE & access & !`mem_err`) | REQ.
- `m_rd`, `m_MemToReg`, `m_reg_data` are combinational passthroughs of the `e_` inputs. `m_RegWrite` is a passthrough except when masked by `mem_err`.
- Non-memory instructions: pure passthrough, zero added latency, no stall.
- `dmem_ack` outside REQ is ignored.

## Timing
- Reset (synchronous, at the edge with `rst_n` = 0), from any state including REQ:
  - state → IDLE; `read_q` = 0; latched request regs = 0.
  - From the next cycle: `dmem_req`/`dmem_we` = 0 and `dmem_be` = 0.
  - An ack from an abandoned request is ignored.
- Cycle sequence for an access presented in cycle 0:
  - Cycle 0: `mem_stall` = 1.
  - Cycle 1: `dmem_req` = 1.
  - Ack in cycle k ≥ 1: `read_q` updates at the end of k.
  - Cycle k+1: DONE, `mem_stall` = 0, `m_read_data` valid, so MEM/WB captures at the end of k+1 (if `stall_in` = 0).
- Minimum memory-op cost: 3 cycles (ack in cycle 1).
- Ack and `stall_in` together in REQ: still → DONE. DONE then holds until `stall_in` falls.
- One outstanding request at most; no pipelining of requests.

## Structure
- Shared package `cpu_pkg`:
  - funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - `mem_state_t` enum {IDLE, REQ, DONE}.
- Sub-module `load_align`: combinational formatter taking (rdata, funct3, off) and returning the 32-bit result. It is reused by any future cache fill path.

## Test plan
- LW at 0x100, ack 2 cycles after req, rdata 0xDEADBEEF:
  - `dmem_addr` = 0x100, be = 1111.
  - `mem_stall` high cycles 0–2.
  - `m_read_data` = 0xDEADBEEF in cycle 3.
- LB at 0x103 with rdata 0x80123456 → 0xFFFFFF80; LBU at the same address → 0x00000080; LHU at 0x102 → 0x00008012.
- SH at 0x102, store_data 0x1234ABCD → `dmem_we` = 1, be = 1100, wdata = 0xABCDABCD; `read_q` unchanged.
- LW at 0x101 → `dmem_req` never asserted, `mem_err` = 1, `m_RegWrite` = 0, `mem_stall` = 0.
- Load completes with `stall_in` held high 3 cycles after ack → remains DONE, no second req, `m_read_data` stable; → IDLE on the first `stall_in` = 0 cycle.
- `rst_n` low for one cycle during REQ, then ack arrives → state IDLE, req = 0, ack ignored, `m_read_data` = 0.
